// File: rtl/pattern_rec_pkg.sv
// Shared constants and state encoding for the serial pattern recogniser.
package pattern_rec_pkg;

  localparam logic ST_UNCFG = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    UNCFG = ST_UNCFG,
    RUN   = ST_RUN
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
  parameter int W = pattern_rec_pkg::DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern matcher with overlap control and a
// saturating match counter.
module seq_pattern_detector
  import pattern_rec_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err,
  output logic             armed
);

  state_t           state;
  // The oldest history bit is shifted out before it can be compared, so
  // only PAT_W-1 bits need storing.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] mask;
  logic             sample;
  logic             hit;
  logic             cfg_legal;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hist_next = {hist, in_bit};
  assign fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
  assign sample    = (state == RUN) && in_valid && !cfg_load;
  assign hit       = sample && (fill_next >= len) &&
                     (((hist_next ^ pattern) & mask) == '0);
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign armed     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNCFG;
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match <= hit;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        state   <= cfg_legal ? RUN : UNCFG;
        cfg_err <= !cfg_legal;
      end else if (sample) begin
        hist <= hist_next[PAT_W-2:0];
        // Non-overlap restarts the fill so matched bits are not reused.
        fill <= (hit && !overlap) ? '0 : fill_next;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (hit),
    .count (match_count)
  );

endmodule
